cache_refill_ctrl: RTL
======================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss-handling front end for generic_n_way_cache. Accepts one CPU read at a time and looks it up via the cache read port.
//  On a hit it returns cache data. On a miss it fetches the word from backing memory over a req/ack handshake.
//  It then writes the word into the cache via the write port, and returns it. Also keeps saturating hit/miss counters.
// PARAMETERS
//  DATA_WIDTH  8    data word width (matches cache)
//  ADDR_WIDTH  8    address width (matches cache)
//  TIMEOUT     16   max cycles waiting for mem_ack; 0 = no timeout
//  CNT_WIDTH   16   width of hit/miss statistics counters
// PORTS
//  clk              in   1           clock, rising edge
//  rst_n            in   1           asynchronous reset, active low
//  cpu_req          in   1           CPU read request
//  cpu_addr         in   ADDR_WIDTH  request address, sampled only on accept
//  cpu_ready        out  1           block idle, request accepted when cpu_req&cpu_ready
//  cpu_valid        out  1           one-cycle response strobe
//  cpu_data         out  DATA_WIDTH  response data (valid with cpu_valid)
//  cpu_err          out  1           response is a memory timeout (with cpu_valid)
//  cache_re         out  1           to cache re
//  cache_read_addr  out  ADDR_WIDTH  to cache read_addr
//  cache_hit        in   1           from cache hit
//  cache_out        in   DATA_WIDTH  from cache out
//  cache_we         out  1           to cache we
//  cache_write_addr out  ADDR_WIDTH  to cache write_addr
//  cache_in         out  DATA_WIDTH  to cache in
//  mem_req          out  1           memory read request, held until ack/timeout
//  mem_addr         out  ADDR_WIDTH  memory read address
//  mem_ack          in   1           memory data valid (one cycle)
//  mem_data         in   DATA_WIDTH  memory read data
//  stat_clr         in   1           synchronous clear of both counters
//  hit_cnt          out  CNT_WIDTH   saturating hit count
//  miss_cnt         out  CNT_WIDTH   saturating miss count
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, addr/data regs 0; cpu_ready=1 and every other output 0 (counters included).
//  - FSM IDLE->LOOKUP->CHECK->{RESP | MISS->FILL->RESP}->IDLE. All outputs decode from registers, with no input-to-output combinational path.
//  - IDLE: cpu_ready=1. On cpu_req, latch cpu_addr into addr_q and go to LOOKUP. cpu_req in any other state is ignored.
//  - LOOKUP: cache_re=1, cache_read_addr=addr_q; ->CHECK (cache registers hit/out at this edge).
//  - CHECK: sample cache_hit/cache_out. Hit: data_q=cache_out, hit_cnt++, ->RESP. Miss: miss_cnt++, timer=0, ->MISS.
//  - MISS: mem_req=1, mem_addr=addr_q. If mem_ack: data_q=mem_data, ->FILL. Otherwise timer++.
//    If TIMEOUT!=0 and timer==TIMEOUT-1 without ack: err_q=1, data_q=0, ->RESP with no fill. Ack on that same edge wins.
//  - FILL: cache_we=1, cache_write_addr=addr_q, cache_in=data_q for exactly one cycle; ->RESP.
//  - RESP: cpu_valid=1, cpu_data=data_q, cpu_err=err_q; ->IDLE, clearing err_q.
//  - Latency: accept cycle = c0. Hit: cpu_valid in c3. Miss with ack in first MISS cycle (c3): FILL c4, cpu_valid c5.
//  - cache_re and cache_we are never high in the same cycle. cache_out/cache_hit are ignored outside CHECK; mem_ack outside MISS is ignored.
//  - Counters saturate at all-ones. stat_clr has priority over an increment on the same edge.
//  - Reset mid-transaction aborts it: mem_req drops immediately, no fill and no response are issued.
//  - Widths: timer is $clog2(TIMEOUT+1) bits, minimum 1.
// TESTING
//  1 Miss then hit: req 0x35; cache_hit=0; mem_ack+0xA5 2 cycles after mem_req.
//    -> one cache_we with addr 0x35, data 0xA5; cpu_valid data 0xA5 err=0.
//    Re-request 0x35 with hit=1, out=0xA5 -> cpu_valid in c3, data 0xA5, no mem_req; hit_cnt=1, miss_cnt=1.
//  2 Timeout: TIMEOUT=4, no mem_ack -> mem_req high exactly 4 cycles, then cpu_valid with err=1, data 0, no cache_we.
//  3 Ack on timeout edge: mem_ack=1 with 0x3C in the 4th MISS cycle -> FILL happens, data 0x3C, err=0.
//  4 Busy ignore: cpu_req held high with a changing cpu_addr during a miss -> only the first address is serviced.
//    cpu_ready=0 until the cycle after cpu_valid.
//  5 Reset mid-MISS: drop rst_n while mem_req=1 -> mem_req=0 asynchronously; no cpu_valid; cpu_ready=1; counters 0.
//  6 Counters: CNT_WIDTH=2, 5 hits -> hit_cnt saturates at 3. stat_clr coincident with a hit -> hit_cnt=0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Miss-handling front end for generic_n_way_cache. Services one CPU read at
//   a time: looks the address up through the cache read port, returns the hit
//   data, or on a miss fetches the word from backing memory over a req/ack
//   handshake, writes it into the cache and returns it. Keeps saturating
//   hit/miss statistics counters.
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   cpu_req/cpu_addr/cpu_ready       request channel, accepted on req & ready
//   cpu_valid/cpu_data/cpu_err       one-cycle response strobe, data, timeout flag
//   cache_re/cache_read_addr         cache lookup port
//   cache_hit/cache_out              cache lookup result (sampled in CHECK only)
//   cache_we/cache_write_addr/cache_in  cache fill port
//   mem_req/mem_addr/mem_ack/mem_data   backing memory read handshake
//   stat_clr, hit_cnt, miss_cnt      statistics clear and counters
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_err,
  output logic                  cache_re,
  output logic [ADDR_WIDTH-1:0] cache_read_addr,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_out,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_write_addr,
  output logic [DATA_WIDTH-1:0] cache_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int TW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TW-1:0] TLIM_W = TLIM[TW-1:0];

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MISS, FILL, RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [TW-1:0]         timer_q;
  logic [CNT_WIDTH-1:0]  hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          state_q <= LOOKUP;
        end
        LOOKUP: state_q <= CHECK;
        CHECK: if (cache_hit) begin
          data_q  <= cache_out;
          state_q <= RESP;
        end else begin
          timer_q <= '0;
          state_q <= MISS;
        end
        MISS: if (mem_ack) begin
          // ack beats a timeout landing on the same edge
          data_q  <= mem_data;
          state_q <= FILL;
        end else if (TIMEOUT != 0 && timer_q == TLIM_W) begin
          err_q   <= 1'b1;
          data_q  <= '0;
          state_q <= RESP;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        FILL: state_q <= RESP;
        RESP: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Statistics: clear wins over a same-edge increment, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (stat_clr) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == CHECK) begin
      if (cache_hit && hit_q != '1)        hit_q  <= hit_q + 1'b1;
      else if (!cache_hit && miss_q != '1) miss_q <= miss_q + 1'b1;
    end
  end

  // All outputs are pure decodes of registered state.
  assign cpu_ready        = (state_q == IDLE);
  assign cpu_valid        = (state_q == RESP);
  assign cpu_data         = data_q;
  assign cpu_err          = err_q;
  assign cache_re         = (state_q == LOOKUP);
  assign cache_read_addr  = addr_q;
  assign cache_we         = (state_q == FILL);
  assign cache_write_addr = addr_q;
  assign cache_in         = data_q;
  assign mem_req          = (state_q == MISS);
  assign mem_addr         = addr_q;
  assign hit_cnt          = hit_q;
  assign miss_cnt         = miss_q;

endmodule
